mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Shares one single-port memory (valid/ready handshake, write when wr_rd_en=1, registered read data with ready one cycle after valid) between NUM_REQ requesters.
- Round-robin grants; each grant drives exactly one memory transaction and returns the response to the granted requester.
- Times out a missing memory ready so requesters never hang.
- Sits between the bus-side masters and the memory instance.

Parameters:
- WIDTH, 8: data width; must match the memory.
- DEPTH, 16: memory depth.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- NUM_REQ, 4: number of requesters, range 2..8.
- TIMEOUT, 4: maximum WAIT cycles before an error completion; must be ≥ 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request.
- req_wr_rd_en_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened; requester n uses slice [n*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata_i  in  NUM_REQ*WIDTH  flattened write data, sliced the same way.
- req_ready_o  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- req_rdata_o  out  WIDTH  read data; valid while any req_ready_o bit is high and the op was a read.
- req_err_o  out  1  timeout flag, qualified by req_ready_o.
- busy_o  out  1  high in every state except IDLE.
- mem_valid_o  out  1  to memory valid_i.
- mem_wr_rd_en_o  out  1  to memory wr_rd_en_i.
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i.
- mem_wdata_o  out  WIDTH  to memory wdata_i.
- mem_rdata_i  in  WIDTH  from memory rdata_o.
- mem_ready_i  in  1  from memory ready_o.

Behaviour:
- Reset: asynchronous and active-high. All outputs are 0, state is IDLE, the round-robin pointer is 0, the timeout counter is 0, and all latched command registers are 0. Reset asserted mid-transaction aborts it with no req_ready_o pulse; the requester must re-issue.
- All outputs are registered.
- Requester rule: req_valid_i and the command fields are held stable until the cycle req_ready_o[n] is high. A transfer completes at the edge where both are high; the requester may change its inputs only after that edge.
- FSM, states IDLE → ISSUE → WAIT → RESP → IDLE:
  - IDLE: if any req_valid_i bit is high, grant the first set bit searching ptr, ptr+1, … (mod NUM_REQ). Latch its op, addr and wdata onto the mem_* outputs, set mem_valid_o=1, then move to ISSUE. If no request, stay in IDLE.
  - ISSUE: mem_valid_o=1 for exactly one cycle. On the next edge clear mem_valid_o, clear the timeout counter, and move to WAIT. mem_valid_o is never high for two consecutive cycles, since the memory would repeat the operation.
  - WAIT:
    - On mem_ready_i=1: latch mem_rdata_i into req_rdata_o (reads only; writes leave req_rdata_o unchanged), set req_ready_o[grant]=1 and req_err_o=0, set ptr=(grant+1) mod NUM_REQ, and move to RESP.
    - Otherwise increment the counter. When it reaches TIMEOUT: pulse req_ready_o[grant] with req_err_o=1, advance ptr, and move to RESP.
  - RESP: req_ready_o is high for this one cycle. Clear req_ready_o and req_err_o, then move to IDLE. No arbitration happens in RESP, which avoids re-granting a request that is still being dropped.
- Latency: request sampled at edge E → mem_valid_o high E+1..E+2 → memory ready E+3 → req_ready_o high E+3..E+4. Throughput is one transaction per 4 cycles minimum.
- A request raised during ISSUE, WAIT or RESP waits for the next IDLE. Non-granted requests are never dropped.
- Starvation bound: a pending request is served within NUM_REQ grants.
- A mem_ready_i arriving in IDLE, ISSUE or RESP is ignored.
- req_rdata_o holds its last read value between reads.

Decomposition:
- Package mem_arb_pkg: FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and the default parameter constants.
- Sub-module mem_rr_picker: combinational round-robin search. Inputs are the request vector and ptr; outputs are grant_valid and grant_idx.

Test Plan (WIDTH=8, DEPTH=16, NUM_REQ=4, TIMEOUT=4, real memory attached):
1. Req0 writes 0xA5 to addr 3, then reads addr 3 → write pulse req_ready_o=0001 with err=0; the read returns req_rdata_o=0xA5 with req_ready_o=0001 at E+3.
2. Req0..3 all request at once with ptr=0 → grants in order 0,1,2,3. The second round starts at 0 again. Each ready pulse is 4 cycles apart.
3. Req2 is served (ptr→3), then req1 and req3 request together → req3 is granted before req1.
4. Memory model holds ready at 0 → req_ready_o pulses with req_err_o=1 after 4 WAIT cycles. The next request completes normally with err=0.
5. rst_i asserted during WAIT of req1's write → all outputs are 0 immediately with no edge needed, and no req_ready_o pulse occurs.
6. Req1 keeps req_valid_i high for 1 extra cycle after its ready → no second grant to req1 occurs before IDLE re-samples. mem_valid_o is never high on 2 consecutive cycles across the whole test.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_DEPTH   = 16;
    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_TIMEOUT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Index width that stays at least one bit for tiny counts.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational round-robin search: first set request at ptr, ptr+1, ... (mod NUM_REQ).
module mem_rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               grant_valid,
    output logic [PTR_W-1:0]   grant_idx
);

    int unsigned      idx;
    logic [PTR_W-1:0] cand;

    // Walk from the farthest offset down so the closest hit to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx  = (32'(ptr) + 32'(i)) % NUM_REQ;
            cand = PTR_W'(idx);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready single-port memory between NUM_REQ requesters,
// one transaction per grant, with a timeout so a silent memory never hangs a requester.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_en_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic                          req_err_o,
    output logic                          busy_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    input  logic [WIDTH-1:0]              mem_rdata_i,
    input  logic                          mem_ready_i
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] cnt;

    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

    // Unflatten the per-requester command buses.
    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign addr_arr[n]  = req_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[n] = req_wdata_i[n*WIDTH +: WIDTH];
    end

    mem_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req         (req_valid_i),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign ptr_next = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            grant          <= '0;
            cnt            <= '0;
            req_ready_o    <= '0;
            req_rdata_o    <= '0;
            req_err_o      <= 1'b0;
            busy_o         <= 1'b0;
            mem_valid_o    <= 1'b0;
            mem_wr_rd_en_o <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant          <= grant_idx;
                        mem_valid_o    <= 1'b1;
                        mem_wr_rd_en_o <= req_wr_rd_en_i[grant_idx];
                        mem_addr_o     <= addr_arr[grant_idx];
                        mem_wdata_o    <= wdata_arr[grant_idx];
                        busy_o         <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Single-cycle valid: a second cycle would repeat the memory op.
                    mem_valid_o <= 1'b0;
                    cnt         <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready_i) begin
                        if (!mem_wr_rd_en_o) begin
                            req_rdata_o <= mem_rdata_i;
                        end
                        req_ready_o <= NUM_REQ'(1) << grant;
                        req_err_o   <= 1'b0;
                        ptr         <= ptr_next;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        req_ready_o <= NUM_REQ'(1) << grant;
                        req_err_o   <= 1'b1;
                        ptr         <= ptr_next;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // No arbitration here: the served requester is still dropping valid.
                    req_ready_o <= '0;
                    req_err_o   <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter with a behavioural memory, directed vectors and randomized batches.
module tb_mem_rr_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int TO = 4;

    logic            clk, rst;
    logic [NR-1:0]   req_valid, req_wr;
    logic [NR*AW-1:0] req_addr;
    logic [NR*W-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [W-1:0]    req_rdata;
    logic            req_err, busy;
    logic            mem_valid, mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata, mem_rdata;
    logic            mem_ready;

    mem_rr_arbiter #(.WIDTH(W), .DEPTH(16), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_wr_rd_en_i(req_wr),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(req_ready), .req_rdata_o(req_rdata), .req_err_o(req_err), .busy_o(busy),
        .mem_valid_o(mem_valid), .mem_wr_rd_en_o(mem_wr), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory: registered read data, ready one cycle after valid.
    logic [W-1:0] mem_arr [16];
    logic mem_ready_r = 1'b0, mem_stall = 1'b0, mem_spur = 1'b0;
    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        mem_ready_r <= 1'b0;
        if (mem_valid && !mem_stall) begin
            if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
            mem_ready_r <= 1'b1;
        end
    end
    assign mem_ready = mem_ready_r | mem_spur;

    // Monitors for whole-run properties.
    int cyc = 0, b2b = 0, multi = 0, mv_pulses = 0, rdy_cycles = 0;
    logic prev_mv = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_valid && prev_mv) b2b <= b2b + 1;
        if (mem_valid && !prev_mv) mv_pulses <= mv_pulses + 1;
        prev_mv <= mem_valid;
        if (req_ready != '0) rdy_cycles <= rdy_cycles + 1;
        if ($countones(req_ready) > 1) multi <= multi + 1;
    end

    int passed = 0, total = 0;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference model state.
    logic [W-1:0] mem_m [16];
    int           ptr_m = 0;
    logic [W-1:0] last_rd = '0;
    logic         c_wr [NR];
    logic [AW-1:0] c_addr [NR];
    logic [W-1:0] c_wd [NR];

    int t_raise = 0;
    int order_q[$], cyc_q[$];
    logic err_q[$];
    logic [W-1:0] rd_q[$];

    task automatic set_cmd(input int k, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
        req_wr[k] = wr;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*W +: W] = d;
        c_wr[k] = wr; c_addr[k] = a; c_wd[k] = d;
    endtask

    task automatic raise(input logic [NR-1:0] mask);
        @(posedge clk); #1;
        req_valid = req_valid | mask;
        t_raise = cyc;
    endtask

    // Collect completions until every raised request has been served (bounded).
    task automatic drain(input int budget);
        logic [NR-1:0] done;
        order_q.delete(); cyc_q.delete(); err_q.delete(); rd_q.delete();
        for (int c = 0; c < budget && req_valid != '0; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                done = req_ready;
                for (int k = 0; k < NR; k++) if (done[k]) order_q.push_back(k);
                err_q.push_back(req_err);
                rd_q.push_back(req_rdata);
                cyc_q.push_back(cyc);
                @(posedge clk); #1;
                req_valid = req_valid & ~done;
            end
        end
        check("drain_complete", 32'(req_valid), 32'h0);
        req_valid = '0;
    endtask

    function automatic logic [31:0] outs();
        return 32'({req_ready, req_rdata, req_err, busy, mem_valid, mem_wr, mem_addr, mem_wdata});
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset_outputs", outs(), 32'h0);
        rst = 1'b0;
        ptr_m = 0; last_rd = '0;
    endtask

    // Raise a batch at once and compare against the round-robin model.
    task automatic run_batch(input logic [NR-1:0] mask, input string tag);
        logic [NR-1:0] pend;
        int exp_o[$];
        logic [W-1:0] exp_r[$];
        int g;
        pend = mask;
        while (pend != '0) begin
            g = -1;
            for (int o = 0; o < NR; o++)
                if (g < 0 && pend[(ptr_m + o) % NR]) g = (ptr_m + o) % NR;
            pend[g] = 1'b0;
            ptr_m = (g + 1) % NR;
            if (c_wr[g]) mem_m[c_addr[g]] = c_wd[g];
            else         last_rd = mem_m[c_addr[g]];
            exp_o.push_back(g);
            exp_r.push_back(last_rd);
        end
        raise(mask);
        drain(20 * NR);
        check($sformatf("%s_count", tag), order_q.size(), exp_o.size());
        for (int i = 0; i < exp_o.size() && i < order_q.size(); i++) begin
            check($sformatf("%s_grant%0d", tag, i), order_q[i], exp_o[i]);
            check($sformatf("%s_rdata%0d", tag, i), 32'(rd_q[i]), 32'(exp_r[i]));
            check($sformatf("%s_err%0d", tag, i), 32'(err_q[i]), 32'h0);
            check($sformatf("%s_gap%0d", tag, i),
                  cyc_q[i] - ((i == 0) ? t_raise : cyc_q[i-1]), (i == 0) ? 3 : 4);
        end
    endtask

    typedef struct {
        int          req;
        logic        wr;
        logic [AW-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int r0, m0, q0;
        logic [NR-1:0] mask;

        vecs[0] = '{0, 1'b1, 4'd3,  8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 4'd3,  8'h00, 8'hA5};
        vecs[2] = '{1, 1'b1, 4'd15, 8'h5A, 8'hA5};
        vecs[3] = '{3, 1'b1, 4'd0,  8'hFF, 8'hA5};
        vecs[4] = '{2, 1'b0, 4'd15, 8'h00, 8'h5A};
        vecs[5] = '{1, 1'b0, 4'd0,  8'h00, 8'hFF};
        vecs[6] = '{3, 1'b0, 4'd3,  8'h00, 8'hA5};

        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        rst = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        do_reset();
        check("idle_busy", 32'(busy), 32'h0);

        // Directed single transactions.
        foreach (vecs[i]) begin
            set_cmd(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].wr) mem_m[vecs[i].addr] = vecs[i].wdata;
            raise(NR'(1) << vecs[i].req);
            drain(20);
            q0 = (order_q.size() > 0) ? order_q[0] : -1;
            check($sformatf("vec%0d_grant", i), q0, vecs[i].req);
            if (order_q.size() > 0) begin
                check($sformatf("vec%0d_err", i), 32'(err_q[0]), 32'h0);
                check($sformatf("vec%0d_rdata", i), 32'(rd_q[0]), 32'(vecs[i].exp_rdata));
                check($sformatf("vec%0d_latency", i), cyc_q[0] - t_raise, 3);
            end
        end

        // All four at once from ptr=0, two rounds.
        do_reset();
        for (int k = 0; k < NR; k++) set_cmd(k, 1'b0, AW'(k == 0 ? 3 : (k == 1 ? 15 : k)), 8'h00);
        run_batch(4'b1111, "round1");
        for (int i = 0; i < order_q.size(); i++) check($sformatf("round1_fixed%0d", i), order_q[i], i);
        run_batch(4'b1111, "round2");
        for (int i = 0; i < order_q.size(); i++) check($sformatf("round2_fixed%0d", i), order_q[i], i);

        // Req2 served alone, then req1 and req3 together: req3 goes first.
        set_cmd(2, 1'b0, 4'd15, 8'h00);
        raise(4'b0100); drain(20);
        set_cmd(1, 1'b0, 4'd3, 8'h00);
        set_cmd(3, 1'b0, 4'd15, 8'h00);
        raise(4'b1010); drain(40);
        check("ptr3_count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("ptr3_first", order_q[0], 3);
            check("ptr3_second", order_q[1], 1);
            check("ptr3_rdata", 32'(rd_q[1]), 32'hA5);
        end

        // Memory never answers: error completion after TIMEOUT wait cycles.
        mem_stall = 1'b1;
        set_cmd(2, 1'b0, 4'd0, 8'h00);
        raise(4'b0100); drain(40);
        mem_stall = 1'b0;
        check("timeout_count", order_q.size(), 1);
        if (order_q.size() == 1) begin
            check("timeout_grant", order_q[0], 2);
            check("timeout_err", 32'(err_q[0]), 32'h1);
            check("timeout_latency", cyc_q[0] - t_raise, 2 + TO);
            check("timeout_rdata_held", 32'(rd_q[0]), 32'hA5);
        end
        set_cmd(0, 1'b0, 4'd15, 8'h00);
        set_cmd(3, 1'b0, 4'd0, 8'h00);
        raise(4'b1001); drain(40);
        check("post_to_count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("post_to_first", order_q[0], 3);
            check("post_to_err", 32'(err_q[0] | err_q[1]), 32'h0);
            check("post_to_rdata", 32'(rd_q[1]), 32'h5A);
        end

        // Spurious memory ready while idle is ignored.
        r0 = rdy_cycles;
        @(posedge clk); #1 mem_spur = 1'b1;
        @(posedge clk); #1 mem_spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("spur_no_ready", rdy_cycles - r0, 0);
        check("spur_idle", 32'({busy, mem_valid}), 32'h0);

        // Reset in the middle of a WAIT aborts silently.
        mem_stall = 1'b1;
        set_cmd(1, 1'b1, 4'd5, 8'h3C);
        raise(4'b0010);
        repeat (4) @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'h1);
        r0 = rdy_cycles;
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", outs(), 32'h0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk); rst = 1'b0; mem_stall = 1'b0;
        ptr_m = 0; last_rd = '0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_pulse", rdy_cycles - r0, 0);
        check("rst_after_idle", outs(), 32'h0);

        // Req1 holds valid past its completion edge: only one transaction results.
        m0 = mv_pulses; r0 = rdy_cycles;
        set_cmd(1, 1'b0, 4'd3, 8'h00);
        raise(4'b0010);
        q0 = 0;
        for (int c = 0; c < 20 && q0 == 0; c++) begin
            @(negedge clk);
            if (req_ready[1]) q0 = 1;
        end
        check("hold_ready_seen", q0, 1);
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_one_issue", mv_pulses - m0, 1);
        check("hold_one_ready", rdy_cycles - r0, 1);
        ptr_m = 2; last_rd = 8'hA5;

        // Randomized batches against the model.
        for (int b = 0; b < 30; b++) begin
            mask = NR'($urandom_range(1, 15));
            for (int k = 0; k < NR; k++)
                set_cmd(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), W'($urandom_range(0, 255)));
            run_batch(mask, $sformatf("rnd%0d", b));
        end

        check("mem_valid_back_to_back", b2b, 0);
        check("ready_onehot", multi, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
